// File: rtl/rt_mem_loader.sv
// Preloads the LiM data memory through port B from a byte stream, one 32-bit write per packed word.
// Per-word cost is 4 + 1 + ack latency + 1 cycles; the source is stalled outside COLLECT.
module rt_mem_loader #(
   parameter int ADDR_WIDTH    = 22,
   parameter int BASE_ADDR     = 0,
   parameter int MAX_WORDS     = 4137,
   parameter int SETTLE_CYCLES = 3,
   parameter int ACK_TIMEOUT   = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic                  src_valid_i,
   input  logic [7:0]            src_data_i,
   input  logic                  src_last_i,
   output logic                  src_ready_o,
   output logic                  own_o,
   output logic                  en_b_o,
   output logic                  we_b_o,
   output logic [ADDR_WIDTH-1:0] addr_b_o,
   output logic [31:0]           wdata_b_o,
   output logic [3:0]            be_b_o,
   input  logic                  rvalid_b_i,
   output logic                  fetch_enable_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic                  truncated_o,
   output logic [15:0]           words_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_COLLECT, S_WRITE, S_WAIT_ACK, S_GAP, S_SETTLE, S_DONE, S_ERROR
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP   = ADDR_WIDTH'(4);
   localparam logic [15:0]           MAX_W       = 16'(MAX_WORDS);
   localparam logic [15:0]           ACK_LAST    = 16'(ACK_TIMEOUT - 1);
   localparam logic [15:0]           SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

   state_t      state, state_nxt;
   logic [1:0]  byte_idx;
   logic        last_seen;
   logic [15:0] cnt;
   logic        accept;
   logic        own_nxt;

   assign accept  = src_valid_i & src_ready_o;
   assign own_nxt = state_nxt inside {S_COLLECT, S_WRITE, S_WAIT_ACK, S_GAP, S_SETTLE};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (start_i) state_nxt = S_COLLECT;
         S_COLLECT:  if (accept && (byte_idx == 2'd3 || src_last_i)) state_nxt = S_WRITE;
         S_WRITE:    state_nxt = S_WAIT_ACK;
         S_WAIT_ACK: begin
            // An ack in the final counted cycle still wins over the timeout.
            if (rvalid_b_i)           state_nxt = S_GAP;
            else if (cnt == ACK_LAST) state_nxt = S_ERROR;
         end
         S_GAP:      state_nxt = (last_seen || words_o == MAX_W) ? S_SETTLE : S_COLLECT;
         S_SETTLE:   if (cnt == SETTLE_LAST) state_nxt = S_DONE;
         default:    state_nxt = state;
      endcase
   end

   // Outputs are registered from the next state so none has a combinational input path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_ready_o    <= 1'b0;
         own_o          <= 1'b0;
         en_b_o         <= 1'b0;
         we_b_o         <= 1'b0;
         addr_b_o       <= BASE;
         wdata_b_o      <= '0;
         be_b_o         <= '0;
         fetch_enable_o <= 1'b0;
         done_o         <= 1'b0;
         error_o        <= 1'b0;
         truncated_o    <= 1'b0;
         words_o        <= '0;
         byte_idx       <= '0;
         last_seen      <= 1'b0;
         cnt            <= '0;
      end else begin
         src_ready_o <= (state_nxt == S_COLLECT);
         en_b_o      <= (state_nxt == S_WRITE);
         own_o       <= own_nxt;
         we_b_o      <= own_nxt;
         if (state_nxt == S_DONE) begin
            done_o         <= 1'b1;
            fetch_enable_o <= 1'b1;
         end
         if (state_nxt == S_ERROR) error_o <= 1'b1;

         if (state_nxt != state)                       cnt <= '0;
         else if (state inside {S_WAIT_ACK, S_SETTLE}) cnt <= cnt + 16'd1;

         case (state)
            S_COLLECT: if (accept) begin
               wdata_b_o[{byte_idx, 3'b000} +: 8] <= src_data_i;
               be_b_o[byte_idx]                   <= 1'b1;
               byte_idx                           <= byte_idx + 2'd1;
               if (src_last_i) last_seen <= 1'b1;
            end
            S_WAIT_ACK: if (rvalid_b_i) words_o <= words_o + 16'd1;
            S_GAP: begin
               addr_b_o  <= addr_b_o + ADDR_STEP;
               wdata_b_o <= '0;
               be_b_o    <= '0;
               byte_idx  <= '0;
               if (!last_seen && words_o == MAX_W && src_valid_i) truncated_o <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
